vectorgates_arbiter: RTL and testbench
======================================

# vectorgates_arbiter

Round-robin arbiter and sequencer that shares one vector-gate datapath among `NUM_REQ` requesters. The datapath computes bitwise-OR, logical-OR and the inverse of two `WIDTH`-bit operands. The block accepts one operand pair per cycle over valid/ready handshakes, registers the datapath result together with the requester ID, and holds it under back-pressure until downstream accepts it. It sits between several producer blocks and a single consumer of gate results.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 3: operand width.
- `CNT_W`, default 16: width of the transaction counter.

Ports:
- `clk`  in  1: clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_ready`  out  NUM_REQ: per-requester accept, one-hot or zero.
- `req_a`  in  NUM_REQ*WIDTH: operand a, requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH: operand b, same packing as `req_a`.
- `resp_valid`  out  1: result register holds a result.
- `resp_ready`  in  1: downstream accepts the result.
- `resp_id`  out  $clog2(NUM_REQ): index of the requester that produced the result.
- `resp_or_bitwise`  out  WIDTH: a | b.
- `resp_or_logical`  out  1: (|a) || (|b).
- `resp_not`  out  2*WIDTH: {~b, ~a}.
- `txn_count`  out  CNT_W: number of accepted requests since reset, saturating.

## Operation
- Two states.
  - EMPTY: the result register is free.
  - FULL: the result register holds a result, `resp_valid`=1.
- `can_accept` = EMPTY, or (FULL and `resp_ready`).
- Arbitration is combinational. Search `req_valid` starting at `rr_ptr` and wrapping modulo NUM_REQ. The first set bit is the grant.
- `req_ready[g]`=1 only for the granted index g, and only when `can_accept`. All other bits are 0.
- Handshake on requester g (`req_valid[g]` && `req_ready[g]`), at the clock edge:
  - capture the datapath outputs for (a_g, b_g) into the result register;
  - set `resp_id`=g;
  - state goes to FULL;
  - `rr_ptr` becomes (g+1) mod NUM_REQ;
  - `txn_count` increments, holding at all-ones.
- Drain without a new grant (FULL, `resp_ready`=1, no grant): state goes to EMPTY and the result fields hold their last value.
- Drain and accept in the same cycle: state stays FULL and the new result replaces the old one. Throughput is 1 result per cycle.
- Back-pressure (FULL, `resp_ready`=0): all `resp_*` outputs hold stable, all `req_ready` are 0, and `rr_ptr` holds.
- `rr_ptr` changes only on a handshake. A requester that drops `req_valid` loses no priority.
- Requester operands are sampled only in the handshake cycle.

## Timing
- Reset values:
  - state EMPTY, `resp_valid`=0;
  - `resp_id`=0, `resp_or_bitwise`=0, `resp_or_logical`=0, `resp_not`=0;
  - `rr_ptr`=0, `txn_count`=0;
  - `req_ready`=0 during the reset cycle.
- Latency: a handshake at edge k gives `resp_valid`=1 and valid result fields after edge k.
- `req_ready` depends combinationally on `req_valid`, `resp_ready` and state. No input depends on `req_ready`, so there are no combinational loops.
- Reset mid-operation: a pending result is discarded, with no response and no `req_ready` in the reset cycle. The pointer returns to 0.
- `rr_ptr` wraps from NUM_REQ-1 to 0. For non-power-of-two NUM_REQ the wrap is explicit, not a bit truncation.

## Structure
- Package `vectorgates_pkg` holds:
  - the state enum {EMPTY, FULL};
  - the function `id_w(n)` = $clog2(n);
  - a packed result struct {or_bitwise, or_logical, not_ab}.
- Sub-module `vectorgates_unit`: purely combinational, parameter WIDTH, inputs a and b, outputs the three results. It is instantiated once and fed by a mux of the granted operands.
- The arbiter holds the FSM, round-robin pointer, result register and counter.

## Test plan
- Single request, NUM_REQ=4, WIDTH=3: requester 0 presents a=3'b010, b=3'b100, with `resp_ready`=1.
  - Expect `req_ready`=4'b0001 that cycle.
  - Next cycle: `resp_valid`=1, `resp_id`=0, `resp_or_bitwise`=3'b110, `resp_or_logical`=1, `resp_not`=6'b011101.
  - `txn_count`=1.
- Zero operands: requester 2 presents a=0, b=0.
  - Expect `resp_or_bitwise`=0, `resp_or_logical`=0, `resp_not`=6'b111111, `resp_id`=2.
- Fairness: all four `req_valid` held high with `resp_ready`=1.
  - Grants occur in order 0,1,2,3,0,1 on consecutive cycles.
  - `resp_valid` stays 1 from the second cycle onward.
  - After 6 cycles, `txn_count`=6.
- Back-pressure: FULL with `resp_ready`=0 for 3 cycles while requesters are valid.
  - `req_ready`=0 throughout, all `resp_*` stable.
  - When `resp_ready` returns to 1, the next grant is the pointer-ordered requester in that same cycle.
- Reset mid-operation: assert `reset` for 1 cycle while FULL with `rr_ptr`=2.
  - Next cycle: `resp_valid`=0, `txn_count`=0.
  - With requesters 1 and 3 valid, the first grant is requester 1.
- Saturation: with CNT_W=4, perform 20 handshakes.
  - `txn_count` stops at 15.

Source files
------------

// File: rtl/vectorgates_pkg.sv
// -----------------------------------------------------------------------------
// vectorgates_pkg
// Shared types for the vector-gate arbiter slice:
//   vg_state_t  - result-register occupancy state {EMPTY, FULL}
//   id_w()      - width of a requester index for n requesters
//   vg_result_t - packed result bundle at the default operand width
// -----------------------------------------------------------------------------
package vectorgates_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } vg_state_t;

    localparam int VG_DEF_WIDTH = 3;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

    // The arbiter declares the same layout locally at its own WIDTH.
    typedef struct packed {
        logic [VG_DEF_WIDTH-1:0]   or_bitwise;
        logic                      or_logical;
        logic [2*VG_DEF_WIDTH-1:0] not_ab;
    } vg_result_t;

endpackage

// File: rtl/vectorgates_unit.sv
// -----------------------------------------------------------------------------
// vectorgates_unit
// Purely combinational vector-gate datapath.
// Ports:
//   a, b        in  WIDTH    operands
//   or_bitwise  out WIDTH    a | b
//   or_logical  out 1        (|a) || (|b)
//   not_ab      out 2*WIDTH  {~b, ~a}
// -----------------------------------------------------------------------------
module vectorgates_unit #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   or_bitwise,
    output logic               or_logical,
    output logic [2*WIDTH-1:0] not_ab
);

    assign or_bitwise = a | b;
    assign or_logical = (|a) || (|b);
    assign not_ab     = {~b, ~a};

endmodule

// File: rtl/vectorgates_arbiter.sv
// -----------------------------------------------------------------------------
// vectorgates_arbiter
// Round-robin arbiter sharing one vectorgates_unit among NUM_REQ requesters.
// One operand pair is accepted per cycle; the result and requester id are
// registered and held until downstream takes them.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready  result handshake
//   resp_id           requester that produced the held result
//   resp_or_bitwise, resp_or_logical, resp_not   held datapath results
//   txn_count         accepted requests since reset, saturating
//
// State table
//   state | meaning
//   EMPTY | result register free, resp_valid = 0
//   FULL  | result register holds a result, resp_valid = 1
// -----------------------------------------------------------------------------
module vectorgates_arbiter
    import vectorgates_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           resp_or_bitwise,
    output logic                       resp_or_logical,
    output logic [2*WIDTH-1:0]         resp_not,
    output logic [CNT_W-1:0]           txn_count
);

    localparam int              ID_W    = id_w(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_EXT = (ID_W+1)'(NUM_REQ);

    typedef struct packed {
        logic [WIDTH-1:0]   or_bitwise;
        logic               or_logical;
        logic [2*WIDTH-1:0] not_ab;
    } res_t;

    vg_state_t        state_q, state_d;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic             can_accept;
    logic             handshake;
    logic [WIDTH-1:0] sel_a, sel_b;
    res_t             unit_res;
    res_t             res_q;
    logic [ID_W-1:0]  id_q;

    // Search from rr_ptr with an explicit modulo wrap so non-power-of-two
    // NUM_REQ never lands on a nonexistent requester.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= NUM_EXT) begin
                sum = sum - NUM_EXT;
            end
            cand = sum[ID_W-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    vectorgates_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .a          (sel_a),
        .b          (sel_b),
        .or_bitwise (unit_res.or_bitwise),
        .or_logical (unit_res.or_logical),
        .not_ab     (unit_res.not_ab)
    );

    // A full register may be refilled in the same cycle it drains.
    assign can_accept = (state_q == EMPTY) || resp_ready;
    assign handshake  = grant_found && can_accept && !reset;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (handshake) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (handshake) begin
                    state_d = FULL;
                end else if (resp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            rr_ptr    <= '0;
            res_q     <= '0;
            id_q      <= '0;
            txn_count <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                res_q  <= unit_res;
                id_q   <= grant_id;
                rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
                if (txn_count != {CNT_W{1'b1}}) begin
                    txn_count <= txn_count + CNT_W'(1);
                end
            end
        end
    end

    assign resp_valid      = (state_q == FULL);
    assign resp_id         = id_q;
    assign resp_or_bitwise = res_q.or_bitwise;
    assign resp_or_logical = res_q.or_logical;
    assign resp_not        = res_q.not_ab;

endmodule

// File: tb/tb_vectorgates_arbiter.sv
module tb_vectorgates_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [2:0]  resp_or_bitwise;
    logic        resp_or_logical;
    logic [5:0]  resp_not;
    logic [3:0]  txn_count;

    int errors = 0;
    int checks = 0;

    vectorgates_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (3),
        .CNT_W   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_or_bitwise (resp_or_bitwise),
        .resp_or_logical (resp_or_logical),
        .resp_not        (resp_not),
        .txn_count       (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'b1111; resp_ready = 1'b1;
        req_a = 12'hFFF; req_b = 12'hFFF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready2: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", resp_id); end
        checks++; if (resp_or_bitwise !== 3'b000) begin errors++; $display("FAIL rst_orb: got %b want 000", resp_or_bitwise); end
        checks++; if (resp_or_logical !== 1'b0) begin errors++; $display("FAIL rst_orl: got %b want 0", resp_or_logical); end
        checks++; if (resp_not !== 6'b000000) begin errors++; $display("FAIL rst_not: got %b want 000000", resp_not); end
        checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", txn_count); end
        reset = 1'b0; req_valid = 4'b0000;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a = {3'b111, 3'b111, 3'b111, 3'b010};
        req_b = {3'b000, 3'b000, 3'b000, 3'b100};
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", resp_id); end
        checks++; if (resp_or_bitwise !== 3'b110) begin errors++; $display("FAIL single_orb: got %b want 110", resp_or_bitwise); end
        checks++; if (resp_or_logical !== 1'b1) begin errors++; $display("FAIL single_orl: got %b want 1", resp_or_logical); end
        checks++; if (resp_not !== 6'b011101) begin errors++; $display("FAIL single_not: got %b want 011101", resp_not); end
        checks++; if (txn_count !== 4'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", txn_count); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", resp_valid); end
        checks++; if (resp_or_bitwise !== 3'b110) begin errors++; $display("FAIL drain_hold: got %b want 110", resp_or_bitwise); end
    endtask

    task automatic test_zero();
        // rr_ptr is 1 here; requester 2 is the only one valid.
        req_valid = 4'b0100;
        req_a = {3'b111, 3'b000, 3'b111, 3'b111};
        req_b = {3'b111, 3'b000, 3'b111, 3'b111};
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL zero_id: got %0d want 2", resp_id); end
        checks++; if (resp_or_bitwise !== 3'b000) begin errors++; $display("FAIL zero_orb: got %b want 000", resp_or_bitwise); end
        checks++; if (resp_or_logical !== 1'b0) begin errors++; $display("FAIL zero_orl: got %b want 0", resp_or_logical); end
        checks++; if (resp_not !== 6'b111111) begin errors++; $display("FAIL zero_not: got %b want 111111", resp_not); end
        checks++; if (txn_count !== 4'd2) begin errors++; $display("FAIL zero_cnt: got %0d want 2", txn_count); end
        tick();
    endtask

    task automatic test_fairness();
        logic [2:0] exp_or [4];
        logic [1:0] exp_id;
        logic [3:0] exp_rdy;
        // a = 1,2,3,4 and b = 1,2,4,0 for requesters 0..3
        exp_or[0] = 3'd1; exp_or[1] = 3'd2; exp_or[2] = 3'd7; exp_or[3] = 3'd4;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b1111;
        req_a = {3'd4, 3'd3, 3'd2, 3'd1};
        req_b = {3'd0, 3'd4, 3'd2, 3'd1};
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_id  = 2'(k % 4);
            exp_rdy = 4'b0001 << exp_id;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
            tick();
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL fair_valid[%0d]: got %b want 1", k, resp_valid); end
            checks++; if (resp_id !== exp_id) begin errors++; $display("FAIL fair_id[%0d]: got %0d want %0d", k, resp_id, exp_id); end
            checks++; if (resp_or_bitwise !== exp_or[exp_id]) begin errors++; $display("FAIL fair_orb[%0d]: got %b want %b", k, resp_or_bitwise, exp_or[exp_id]); end
        end
        checks++; if (txn_count !== 4'd6) begin errors++; $display("FAIL fair_cnt: got %0d want 6", txn_count); end
    endtask

    task automatic test_backpressure();
        // Holding result from requester 1 (a=2, b=2); rr_ptr is 2.
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
            tick();
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, resp_valid); end
            checks++; if (resp_id !== 2'd1) begin errors++; $display("FAIL bp_id[%0d]: got %0d want 1", k, resp_id); end
            checks++; if (resp_or_bitwise !== 3'b010) begin errors++; $display("FAIL bp_orb[%0d]: got %b want 010", k, resp_or_bitwise); end
            checks++; if (resp_not !== 6'b101101) begin errors++; $display("FAIL bp_not[%0d]: got %b want 101101", k, resp_not); end
            checks++; if (txn_count !== 4'd6) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d want 6", k, txn_count); end
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
        tick();
        checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL bp_release_id: got %0d want 2", resp_id); end
        checks++; if (resp_or_bitwise !== 3'b111) begin errors++; $display("FAIL bp_release_orb: got %b want 111", resp_or_bitwise); end
        checks++; if (txn_count !== 4'd7) begin errors++; $display("FAIL bp_release_cnt: got %0d want 7", txn_count); end
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 3; only requester 1 valid -> grant 1, rr_ptr becomes 2.
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_pre_ready: got %b want 0010", req_ready); end
        tick();
        checks++; if (txn_count !== 4'd8) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 8", txn_count); end
        reset = 1'b1; req_valid = 4'b1010; resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
        tick();
        reset = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
        checks++; if (txn_count !== 4'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", txn_count); end
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_ready: got %b want 0010", req_ready); end
        tick();
        checks++; if (resp_id !== 2'd1) begin errors++; $display("FAIL mid_first_id: got %0d want 1", resp_id); end
        req_valid = 4'b0000;
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14) begin
                checks++; if (txn_count !== 4'd14) begin errors++; $display("FAIL sat_cnt14: got %0d want 14", txn_count); end
            end
            if (n == 15) begin
                checks++; if (txn_count !== 4'd15) begin errors++; $display("FAIL sat_cnt15: got %0d want 15", txn_count); end
            end
        end
        checks++; if (txn_count !== 4'd15) begin errors++; $display("FAIL sat_cnt20: got %0d want 15", txn_count); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", resp_valid); end
        req_valid = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        test_reset();
        test_single();
        test_zero();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
